// File: rtl/vga_scan_controller.sv
// ----------------------------------------------------------------------------
// vga_scan_controller
//
// Raster scan controller for the VGA output path. It generates the horizontal
// and vertical timing and requests each active pixel from an upstream source.
// The returned colour is aligned with hsync, vsync and blanking, so all of
// them leave the block two clocks after the counter state that produced them.
//
// Ports
//   clk           pixel clock (single clock domain)
//   rst_n         asynchronous active-low reset
//   enable        run request; a deassert takes effect at the end of a frame
//   clr_underflow one-cycle pulse that clears the sticky underflow flag
//   pix_req       request for pixel (pix_x, pix_y); x/y are 0 when idle
//   pix_x, pix_y  requested column / row
//   pix_valid     source data valid, sampled one cycle after pix_req
//   pix_r/g/b     source colour
//   reg_r/g/b     registered colour to the pin stage
//   hsync, vsync  sync pulses at SYNC_POL level
//   blank_n       high while the output pixel is in the active area
//   frame_start   one-cycle pulse at counter position (0,0) while running
//   underflow     sticky flag: an active pixel arrived without pix_valid
// ----------------------------------------------------------------------------
module vga_scan_controller #(
   parameter int          H_ACTIVE = 640,
   parameter int          H_FP     = 16,
   parameter int          H_SYNC   = 96,
   parameter int          H_BP     = 48,
   parameter int          V_ACTIVE = 480,
   parameter int          V_FP     = 10,
   parameter int          V_SYNC   = 2,
   parameter int          V_BP     = 33,
   parameter logic        SYNC_POL = 1'b0,
   parameter logic [23:0] FILL_RGB = 24'h000000,
   parameter int          CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             clr_underflow,
   output logic             pix_req,
   output logic [CNT_W-1:0] pix_x,
   output logic [CNT_W-1:0] pix_y,
   input  logic             pix_valid,
   input  logic [7:0]       pix_r,
   input  logic [7:0]       pix_g,
   input  logic [7:0]       pix_b,
   output logic [7:0]       reg_r,
   output logic [7:0]       reg_g,
   output logic [7:0]       reg_b,
   output logic             hsync,
   output logic             vsync,
   output logic             blank_n,
   output logic             frame_start,
   output logic             underflow
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t           state;
   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;

   logic running;
   logic active_p0;
   logic hs_p0;
   logic vs_p0;

   logic act_p1;
   logic hs_p1;
   logic vs_p1;

   // Run state and raster counters. Leaving RUN only happens on the last
   // pixel of a frame, so a mid-frame deassert always completes the frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               h_cnt <= '0;
               v_cnt <= '0;
               if (enable) state <= RUN;
            end
            RUN: begin
               if (h_cnt == H_LAST) begin
                  h_cnt <= '0;
                  if (v_cnt == V_LAST) begin
                     v_cnt <= '0;
                     if (!enable) state <= IDLE;
                  end else begin
                     v_cnt <= v_cnt + 1'b1;
                  end
               end else begin
                  h_cnt <= h_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Stage 0: decode the current counter position
   assign running   = (state == RUN);
   assign active_p0 = running && (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
   assign hs_p0     = running && (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   // vsync spans whole lines, so it depends on v_cnt only
   assign vs_p0     = running && (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

   assign pix_req     = active_p0;
   assign pix_x       = active_p0 ? h_cnt : '0;
   assign pix_y       = active_p0 ? v_cnt : '0;
   assign frame_start = running && (h_cnt == '0) && (v_cnt == '0);

   // Stage 1: carry timing terms while the source returns the pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         act_p1 <= 1'b0;
         hs_p1  <= 1'b0;
         vs_p1  <= 1'b0;
      end else begin
         act_p1 <= active_p0;
         hs_p1  <= hs_p0;
         vs_p1  <= vs_p0;
      end
   end

   // Output stage: colour, syncs and blanking all registered together
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blank_n   <= 1'b0;
         reg_r     <= 8'h00;
         reg_g     <= 8'h00;
         reg_b     <= 8'h00;
         hsync     <= ~SYNC_POL;
         vsync     <= ~SYNC_POL;
         underflow <= 1'b0;
      end else begin
         blank_n <= act_p1;
         hsync   <= hs_p1 ? SYNC_POL : ~SYNC_POL;
         vsync   <= vs_p1 ? SYNC_POL : ~SYNC_POL;
         if (act_p1 && pix_valid) begin
            reg_r <= pix_r;
            reg_g <= pix_g;
            reg_b <= pix_b;
         end else if (act_p1) begin
            reg_r <= FILL_RGB[23:16];
            reg_g <= FILL_RGB[15:8];
            reg_b <= FILL_RGB[7:0];
         end else begin
            reg_r <= 8'h00;
            reg_g <= 8'h00;
            reg_b <= 8'h00;
         end
         // a missing pixel outranks a simultaneous clear
         if (act_p1 && !pix_valid) underflow <= 1'b1;
         else if (clr_underflow)   underflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_scan_controller.sv
// ----------------------------------------------------------------------------
// Testbench for vga_scan_controller with a reduced raster (8 x 6 totals).
// A reference raster model predicts the stage-0 outputs each cycle and pushes
// the expected output-stage values into a queue; they are popped and compared
// two cycles later when the DUT presents them.
// ----------------------------------------------------------------------------
module tb_vga_scan_controller;

   localparam int          CW   = 11;
   localparam logic        SP   = 1'b0;
   localparam logic [23:0] FILL = 24'h0000FF;

   logic          clk;
   logic          rst_n;
   logic          enable;
   logic          clr_underflow;
   logic          pix_req;
   logic [CW-1:0] pix_x;
   logic [CW-1:0] pix_y;
   logic          pix_valid;
   logic [7:0]    pix_r, pix_g, pix_b;
   logic [7:0]    reg_r, reg_g, reg_b;
   logic          hsync, vsync, blank_n, frame_start, underflow;

   vga_scan_controller #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .SYNC_POL(SP), .FILL_RGB(FILL), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clr_underflow(clr_underflow),
      .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y),
      .pix_valid(pix_valid), .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
      .reg_r(reg_r), .reg_g(reg_g), .reg_b(reg_b),
      .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
      .frame_start(frame_start), .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        blank;
      logic [23:0] rgb;
      logic        hs;
      logic        vs;
   } exp_t;

   exp_t sbq[$];

   int n_cmp = 0;
   int n_bad = 0;

   // reference raster model: state of the upcoming cycle
   bit m_run = 0;
   int mh = 0;
   int mv = 0;

   bit   prev_req  = 0;
   bit   prev_drop = 0;
   int   prev_x    = 0;
   int   prev_y    = 0;
   logic uf_exp    = 1'b0;

   bit drop_on       = 0;
   int drop_x        = 0;
   int drop_y        = 0;
   bit clr_with_drop = 0;
   int fs_seen       = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_advance(input bit en);
      if (!m_run) begin
         if (en) m_run = 1;
      end else if (mh == 7) begin
         mh = 0;
         if (mv == 5) begin
            mv = 0;
            if (!en) m_run = 0;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
   endtask

   task automatic push_idle();
      exp_t e;
      e.blank = 1'b0; e.rgb = 24'h0; e.hs = ~SP; e.vs = ~SP;
      sbq.push_back(e);
   endtask

   task automatic step(input bit en, input bit clr);
      exp_t e;
      logic vdrv, cdrv;
      bit   req_now, drop_now;
      @(posedge clk); #1;
      if (sbq.size() == 2) begin
         e = sbq.pop_front();
         chk("blank_n", 32'(blank_n), 32'(e.blank));
         chk("rgb", 32'({reg_r, reg_g, reg_b}), 32'(e.rgb));
         chk("hsync", 32'(hsync), 32'(e.hs));
         chk("vsync", 32'(vsync), 32'(e.vs));
      end
      chk("underflow", 32'(underflow), 32'(uf_exp));
      if (frame_start) fs_seen++;

      // drive this cycle's inputs: source answers last cycle's request
      enable = en;
      if (prev_req) begin
         vdrv  = !prev_drop;
         pix_r = 8'(prev_x);
         pix_g = 8'(prev_y);
         pix_b = 8'hA5;
      end else begin
         vdrv  = 1'($urandom_range(0, 1));
         pix_r = 8'($urandom);
         pix_g = 8'($urandom);
         pix_b = 8'($urandom);
      end
      pix_valid     = vdrv;
      cdrv          = clr | (prev_drop & clr_with_drop);
      clr_underflow = cdrv;
      if (prev_req && !vdrv) uf_exp = 1'b1;
      else if (cdrv)         uf_exp = 1'b0;

      req_now = m_run && (mh < 4) && (mv < 3);
      chk("pix_req", 32'(pix_req), 32'(req_now));
      chk("pix_x", 32'(pix_x), req_now ? 32'(mh) : 32'd0);
      chk("pix_y", 32'(pix_y), req_now ? 32'(mv) : 32'd0);
      chk("frame_start", 32'(frame_start), 32'(m_run && mh == 0 && mv == 0));

      drop_now = req_now && drop_on && (mh == drop_x) && (mv == drop_y);
      e.blank  = req_now;
      e.rgb    = !req_now ? 24'h0 : drop_now ? FILL : {8'(mh), 8'(mv), 8'hA5};
      e.hs     = (m_run && mh >= 5 && mh <= 6) ? SP : ~SP;
      e.vs     = (m_run && mv == 4) ? SP : ~SP;
      sbq.push_back(e);

      prev_req  = req_now;
      prev_drop = drop_now;
      prev_x    = mh;
      prev_y    = mv;
      model_advance(en);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_pix_req"}, 32'(pix_req), 32'd0);
      chk({tag, "_pix_xy"}, 32'({pix_x, pix_y}), 32'd0);
      chk({tag, "_rgb"}, 32'({reg_r, reg_g, reg_b}), 32'd0);
      chk({tag, "_syncs"}, 32'({hsync, vsync}), 32'({~SP, ~SP}));
      chk({tag, "_blank_n"}, 32'(blank_n), 32'd0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      chk({tag, "_underflow"}, 32'(underflow), 32'd0);
   endtask

   // reset release with the model and scoreboard restarted to match
   task automatic release_reset(input bit en);
      @(negedge clk);
      enable = en;
      rst_n  = 1'b1;
      m_run = 0; mh = 0; mv = 0;
      prev_req = 0; prev_drop = 0; uf_exp = 1'b0;
      sbq.delete();
      push_idle();
      push_idle();
      model_advance(en);
   endtask

   initial begin
      int guard;
      rst_n = 1'b0; enable = 1'b0; clr_underflow = 1'b0;
      pix_valid = 1'b0; pix_r = 8'h00; pix_g = 8'h00; pix_b = 8'h00;
      repeat (3) @(posedge clk);
      #1 check_reset_values("por");
      release_reset(1'b0);

      // idle with enable low
      repeat (20) step(1'b0, 1'b0);

      // two clean frames
      fs_seen = 0;
      repeat (96) step(1'b1, 1'b0);
      chk("frames_seen", 32'(fs_seen), 32'd2);

      // drop pixel (2,1), then clear
      drop_on = 1; drop_x = 2; drop_y = 1;
      repeat (48) step(1'b1, 1'b0);
      drop_on = 0;
      step(1'b1, 1'b1);
      repeat (4) step(1'b1, 1'b0);

      // drop (3,2) with a clear in the same cycle: set wins
      drop_on = 1; drop_x = 3; drop_y = 2; clr_with_drop = 1;
      repeat (48) step(1'b1, 1'b0);
      drop_on = 0; clr_with_drop = 0;
      step(1'b1, 1'b1);
      repeat (3) step(1'b1, 1'b0);

      // deassert enable at (1,1): frame completes, then idle
      guard = 0;
      while (!(m_run && mh == 1 && mv == 1) && guard < 100) begin
         step(1'b1, 1'b0);
         guard++;
      end
      chk("reach_1_1", 32'(guard < 100), 32'd1);
      repeat (70) step(1'b0, 1'b0);

      // restart, then reset mid-frame at (2,2)
      guard = 0;
      while (!(m_run && mh == 2 && mv == 2) && guard < 200) begin
         step(1'b1, 1'b0);
         guard++;
      end
      chk("reach_2_2", 32'(guard < 200), 32'd1);
      @(posedge clk); #1;
      chk("pre_rst_pix_req", 32'(pix_req), 32'd1);
      rst_n = 1'b0;
      #1 check_reset_values("mid_rst");
      repeat (2) @(posedge clk);
      #1 check_reset_values("hold_rst");
      release_reset(1'b1);
      repeat (60) step(1'b1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
